adder_sequencer_8bit: RTL and testbench

Multi-cycle controller that computes wide additions and subtractions by running the team's shared 8-bit ripple adder (`full_adder_8bit`) one byte per clock, least-significant byte first. A registered carry is chained between bytes. It sits between a requester issuing BYTES-wide operand pairs and a consumer of the result. The two sides use a valid/ready handshake on each. Exactly one `full_adder_8bit` instance is used; no other adder logic is permitted.

---
 rtl/adder_sequencer_8bit.sv | 131 +++++++++++++
 tb/tb_adder_sequencer_8bit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sequencer_8bit.sv
// adder_sequencer_8bit: wide add/subtract built from one shared 8-bit ripple
// adder. The adder is walked over the operands one byte per clock, least
// significant byte first, and the carry between bytes lives in a register.
// Valid/ready handshakes are used on both the request side and the result side.

// Shared 8-bit ripple-carry adder: eight chained full-adder cells.
module full_adder_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic [8:0] w_c;

    assign w_c[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_bit
            assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[8];
endmodule

module adder_sequencer_8bit #(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] a,
    input  logic [8*BYTES-1:0] b,
    input  logic               sub,
    input  logic               carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] sum,
    output logic               carry_out,
    output logic               overflow
);
    localparam int W    = 8 * BYTES;
    localparam int IDXW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_c;
    logic            r_sub;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;

    logic [7:0]      w_fa_a;
    logic [7:0]      w_fa_b;
    logic [7:0]      w_fa_sum;
    logic            w_fa_cout;

    // Current operand byte; the subtrahend is inverted here and the +1 comes
    // from the carry register being preset to 1 on accept.
    assign w_fa_a = r_a[8*r_idx +: 8];
    assign w_fa_b = r_b[8*r_idx +: 8] ^ {8{r_sub}};

    full_adder_8bit u_fa (
        .i_a    (w_fa_a),
        .i_b    (w_fa_b),
        .i_cin  (r_c),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // Sequencer: accept in IDLE, one byte per cycle in RUN, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_c     <= sub ? 1'b1 : carry_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[8*r_idx +: 8] <= w_fa_sum;
                    r_c                 <= w_fa_cout;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no path from in_valid/out_ready.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        sum       = r_sum;
        carry_out = out_valid & r_c;
        overflow  = out_valid
                  & (r_a[W-1] == (r_b[W-1] ^ r_sub))
                  & (r_sum[W-1] != r_a[W-1]);
    end
endmodule

// File: tb/tb_adder_sequencer_8bit.sv
// Testbench for adder_sequencer_8bit: directed vectors with literal
// expectations, plus an arithmetic reference model checked every cycle.
module tb_adder_sequencer_8bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;

    // BYTES=1 instance
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [7:0]  a1 = '0;
    logic [7:0]  b1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [7:0]  sum1;
    logic        carry_out1;
    logic        overflow1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_sequencer_8bit #(.BYTES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    adder_sequencer_8bit #(.BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(1'b0), .carry_in(1'b0),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry_out(carry_out1), .overflow(overflow1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 busy (m_left cycles to go), 2 result held.
    int          m_state = 0;
    int          m_left  = 0;
    logic [31:0] m_sum   = '0;
    logic        m_c     = 1'b0;
    logic        m_o     = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_left  = 0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    logic [31:0] be;
                    logic [32:0] full;
                    be     = sub ? ~b : b;
                    full   = {1'b0, a} + {1'b0, be} + 33'(sub ? 1'b1 : carry_in);
                    m_sum  = full[31:0];
                    m_c    = full[32];
                    m_o    = (a[31] == be[31]) && (m_sum[31] != a[31]);
                    m_left = 4;
                    m_state = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_in_ready", in_ready, (m_state == 0));
        chk("m_out_valid", out_valid, (m_state == 2));
        if (m_state == 2) begin
            chk("m_sum", sum, m_sum);
            chk("m_carry_out", carry_out, m_c);
            chk("m_overflow", overflow, m_o);
        end else begin
            chk("m_carry_out_idle", carry_out, 0);
            chk("m_overflow_idle", overflow, 0);
        end
        chk("inr_outv_excl", in_ready & out_valid, 0);
    end

    // Issue one op, wait for result, check literal expectations, leave it in DONE.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic icin);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 1, 0);
        a = ia; b = ib; sub = isub; carry_in = icin; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat,
                               input logic [31:0] es, input logic ec, input logic eo);
        int lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, carry_out, ec);
        chk({name, "_ovf"}, overflow, eo);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] hs;
        logic        hc, ho;

        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", carry_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Byte-boundary carry
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result("bytecarry", 4, 32'h0000_0100, 1'b0, 1'b0);
        release_result();

        // Full ripple with carry out
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        wait_result("ripple", 4, 32'h0000_0000, 1'b1, 1'b0);
        release_result();

        // Subtract with borrow, carry_in ignored
        issue(32'd5, 32'd7, 1'b1, 1'b1);
        wait_result("sub_borrow", 4, 32'hFFFF_FFFE, 1'b0, 1'b0);
        release_result();

        // Signed overflow
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result("ovf", 4, 32'h8000_0000, 1'b0, 1'b1);
        release_result();

        // Subtract without borrow and negative-minus-positive overflow
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        wait_result("sub_ovf", 4, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure with input churn while result is held
        hs = sum; hc = carry_out; ho = overflow;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; sub = i[0]; carry_in = ~i[0]; in_valid = 1'b1;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, hs);
            chk("bp_cout", carry_out, hc);
            chk("bp_ovf", overflow, ho);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_in_ready", in_ready, 1);
            chk("post_no_result", out_valid, 0);
        end

        // Reset mid-RUN
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rrst_out_valid", out_valid, 0);
        chk("rrst_in_ready", in_ready, 1);
        chk("rrst_sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rrst_no_result", out_valid, 0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_result("after_rst", 4, 32'h2345_6789, 1'b0, 1'b0);
        release_result();

        // BYTES=1 instance
        begin
            int lat = 0;
            @(negedge clk);
            chk("b1_in_ready", in_ready1, 1);
            a1 = 8'h80; b1 = 8'h80; in_valid1 = 1'b1;
            @(posedge clk);
            #1 in_valid1 = 1'b0;
            while (lat < 10) begin
                @(posedge clk);
                lat++;
                #1;
                if (out_valid1) break;
            end
            chk("b1_lat", lat, 1);
            chk("b1_sum", 32'(sum1), 32'h00);
            chk("b1_cout", carry_out1, 1);
            chk("b1_ovf", overflow1, 1);
            @(negedge clk);
            out_ready1 = 1'b1;
            @(posedge clk);
            #1 out_ready1 = 1'b0;
            @(negedge clk);
            chk("b1_idle", in_ready1, 1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
